// File: rtl/seq_mult_param.sv
// seq_mult_param: iterative shift-add multiplier, signed or unsigned operands.
// The operands are turned into magnitudes when the request is accepted. The
// unsigned magnitudes are multiplied over WIDTH iterations. One final cycle
// applies the result sign and registers the 2*WIDTH-bit product into HI/LO.
module seq_mult_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed_Mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI_Out,
  output logic [WIDTH-1:0] LO_Out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   ONE_C     = CNT_W'(1);
  localparam logic [WIDTH-1:0]   ONE_W     = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_P     = (2*WIDTH)'(1);

  state_t               state_reg, state_next;
  logic [2*WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0]   prod_reg;
  logic [WIDTH-1:0]     mplier_reg;
  logic [CNT_W-1:0]     count_reg;
  logic                 neg_reg;
  logic                 done_reg;
  logic [WIDTH-1:0]     hi_reg;
  logic [WIDTH-1:0]     lo_reg;

  logic                 sign_a, sign_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   prod_fixed;

  // Operand magnitudes at request time. The most negative value maps onto
  // itself, and that value read as unsigned is already the correct magnitude.
  always_comb begin
    sign_a = Signed_Mode & A[WIDTH-1];
    sign_b = Signed_Mode & B[WIDTH-1];
    mag_a  = sign_a ? (~A + ONE_W) : A;
    mag_b  = sign_b ? (~B + ONE_W) : B;
  end

  // Partial product for this iteration: the shifted multiplicand gated by
  // the current multiplier LSB.
  for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
    assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
  end

  // Apply the result sign to the accumulated unsigned product.
  always_comb begin
    prod_fixed = neg_reg ? (~prod_reg + ONE_P) : prod_reg;
  end

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: accept a request in IDLE. Run WIDTH iterations.
  // Use one cycle to apply the sign.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (count_reg == LAST_ITER) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load operands, run the shift-add steps, and publish the result.
  // HI/LO are written only in FIX, so they hold their value throughout an operation.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mcand_reg  <= '0;
      prod_reg   <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      neg_reg    <= 1'b0;
      done_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (Start) begin
            mcand_reg  <= {{WIDTH{1'b0}}, mag_a};
            mplier_reg <= mag_b;
            prod_reg   <= '0;
            count_reg  <= '0;
            neg_reg    <= sign_a ^ sign_b;
          end
        end
        RUN: begin
          prod_reg   <= prod_reg + addend;
          mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
          mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
          count_reg  <= count_reg + ONE_C;
        end
        FIX: begin
          hi_reg   <= prod_fixed[2*WIDTH-1:WIDTH];
          lo_reg   <= prod_fixed[WIDTH-1:0];
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Busy   = (state_reg == RUN) || (state_reg == FIX);
  assign Done   = done_reg;
  assign HI_Out = hi_reg;
  assign LO_Out = lo_reg;

endmodule

// File: tb/tb_seq_mult_param.sv
// Testbench for seq_mult_param: a 32-bit instance and an 8-bit instance.
// The stimulus pushes each expected result into a queue. Monitors pop an entry on every Done.
module tb_seq_mult_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total = 0;

  // 32-bit DUT
  logic        start32 = 1'b0, sm32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32;
  logic [31:0] hi32, lo32;

  seq_mult_param #(.WIDTH(32), .CNT_W(6)) dut32 (
    .Clock(clk), .Reset(rst_n), .Start(start32), .Signed_Mode(sm32),
    .A(a32), .B(b32), .Busy(busy32), .Done(done32), .HI_Out(hi32), .LO_Out(lo32)
  );

  // 8-bit DUT
  logic       start8 = 1'b0, sm8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8;
  logic [7:0] hi8, lo8;

  seq_mult_param #(.WIDTH(8), .CNT_W(4)) dut8 (
    .Clock(clk), .Reset(rst_n), .Start(start8), .Signed_Mode(sm8),
    .A(a8), .B(b8), .Busy(busy8), .Done(done8), .HI_Out(hi8), .LO_Out(lo8)
  );

  typedef struct { logic [31:0] hi; logic [31:0] lo; int due; } exp32_t;
  typedef struct { logic [7:0] hi; logic [7:0] lo; int due; } exp8_t;
  exp32_t q32[$];
  exp8_t  q8[$];
  int done_cnt32 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor for the 32-bit instance
  always @(negedge clk) begin
    if (rst_n && done32) begin
      done_cnt32++;
      if (q32.size() == 0) begin
        total++;
        $display("FAIL done32_unexpected: Done at cycle %0d with HI=0x%0h LO=0x%0h, no result expected",
                 cyc, hi32, lo32);
      end else begin
        exp32_t e;
        e = q32.pop_front();
        $display("done32 cycle %0d: HI=0x%08h LO=0x%08h (expected 0x%08h 0x%08h)", cyc, hi32, lo32, e.hi, e.lo);
        check("hi32", hi32, e.hi);
        check("lo32", lo32, e.lo);
        check("latency32", cyc, e.due);
        check("busy32_in_done", busy32, 1'b0);
      end
    end
  end

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        total++;
        $display("FAIL done8_unexpected: Done at cycle %0d with HI=0x%0h LO=0x%0h, no result expected",
                 cyc, hi8, lo8);
      end else begin
        exp8_t e;
        e = q8.pop_front();
        $display("done8 cycle %0d: HI=0x%02h LO=0x%02h (expected 0x%02h 0x%02h)", cyc, hi8, lo8, e.hi, e.lo);
        check("hi8", hi8, e.hi);
        check("lo8", lo8, e.lo);
        check("latency8", cyc, e.due);
        check("busy8_in_done", busy8, 1'b0);
      end
    end
  end

  // Caller is at a negedge. Present the request, let one edge sample it, then retire it.
  task automatic launch32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                          input logic push, input logic [31:0] eh, input logic [31:0] el);
    start32 = 1'b1; a32 = a; b32 = b; sm32 = sm;
    @(posedge clk); #1;
    start32 = 1'b0;
    check("busy32_after_start", busy32, 1'b1);
    if (push) q32.push_back('{eh, el, cyc + 33});
  endtask

  task automatic start32_op(input logic [31:0] a, input logic [31:0] b, input logic sm,
                            input logic push, input logic [31:0] eh, input logic [31:0] el);
    int w;
    @(negedge clk);
    w = 0;
    while (busy32 && w < 200) begin @(negedge clk); w++; end
    if (busy32) begin total++; $display("FAIL wait_idle32: busy still 1 after %0d cycles", w); end
    launch32(a, b, sm, push, eh, el);
  endtask

  task automatic start8_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                           input logic [7:0] eh, input logic [7:0] el);
    int w;
    @(negedge clk);
    w = 0;
    while (busy8 && w < 100) begin @(negedge clk); w++; end
    if (busy8) begin total++; $display("FAIL wait_idle8: busy still 1 after %0d cycles", w); end
    start8 = 1'b1; a8 = a; b8 = b; sm8 = sm;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("busy8_after_start", busy8, 1'b1);
    q8.push_back('{eh, el, cyc + 9});
  endtask

  initial begin
    int w;
    int saved;
    logic [7:0] ra, rb;
    logic rs;
    int p;
    logic [15:0] p16;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy32", busy32, 1'b0);
    check("rst_done32", done32, 1'b0);
    check("rst_hi32", hi32, 32'h0);
    check("rst_lo32", lo32, 32'h0);
    check("rst_busy8", busy8, 1'b0);
    rst_n = 1'b1;

    // Test 1: unsigned multiply
    start32_op(32'd6, 32'd7, 1'b0, 1'b1, 32'h0, 32'h2A);
    // Test 2: signed, then unsigned with the same operands
    start32_op(32'hFFFFFFFD, 32'd5, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);
    start32_op(32'hFFFFFFFD, 32'd5, 1'b0, 1'b1, 32'h00000004, 32'hFFFFFFF1);
    // Test 3: extreme operands
    start32_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFE, 32'h00000001);
    start32_op(32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h40000000, 32'h00000000);

    // Test 4: Start during RUN is ignored, and HI/LO keep the previous result
    start32_op(32'h12345678, 32'h10, 1'b0, 1'b1, 32'h00000001, 32'h23456780);
    repeat (5) @(negedge clk);
    check("hold_hi32_midrun", hi32, 32'h40000000);
    check("hold_lo32_midrun", lo32, 32'h00000000);
    start32 = 1'b1; a32 = 32'hFFFFFFFF; b32 = 32'h2; sm32 = 1'b0;
    @(posedge clk); #1;
    start32 = 1'b0; a32 = 32'h0; b32 = 32'h0;
    // Back-to-back: request in the Done cycle
    w = 0;
    do begin @(negedge clk); w++; end while (!done32 && w < 100);
    if (!done32) begin total++; $display("FAIL wait_done32: no Done within %0d cycles", w); end
    launch32(32'd7, 32'hFFFFFFFE, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF2);

    // Test 5: asynchronous reset mid-RUN aborts the operation
    start32_op(32'hDEADBEEF, 32'd3, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (10) @(negedge clk);
    saved = done_cnt32;
    #2 rst_n = 1'b0;
    #1;
    check("async_busy32", busy32, 1'b0);
    check("async_done32", done32, 1'b0);
    check("async_hi32", hi32, 32'h0);
    check("async_lo32", lo32, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_done_after_abort", done_cnt32, saved);
    start32_op(32'd2, 32'd3, 1'b0, 1'b1, 32'h0, 32'h6);

    // Test 6: WIDTH=8
    start8_op(8'h80, 8'h7F, 1'b1, 8'hC0, 8'h80);
    start8_op(8'hFF, 8'hFF, 1'b0, 8'hFE, 8'h01);
    start8_op(8'hFF, 8'hFF, 1'b1, 8'h00, 8'h01);
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      if (rs) p = int'($signed(ra)) * int'($signed(rb));
      else    p = int'(ra) * int'(rb);
      p16 = p[15:0];
      start8_op(ra, rb, rs, p16[15:8], p16[7:0]);
    end

    // Drain the outstanding results
    w = 0;
    while ((q32.size() != 0 || q8.size() != 0) && w < 200) begin @(negedge clk); w++; end
    if (q32.size() != 0 || q8.size() != 0) begin
      total++;
      $display("FAIL drain: %0d/%0d results still outstanding", q32.size(), q8.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
